// File: rtl/gmii_arb_pkg.sv
// Shared encodings and default sizing for the GMII transmit arbiter.
package gmii_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    IFG   = 2'd3
  } arb_state_t;

  localparam logic SEL_VID = 1'b0;
  localparam logic SEL_AUD = 1'b1;

  localparam int VID_BURST  = 160;
  localparam int AUD_BURST  = 8;
  localparam int IFG_CYCLES = 12;

endpackage

// File: rtl/gmii_arb_timer.sv
// Saturating up-counter with synchronous clear/enable and a >= THRESH flag.
module gmii_arb_timer #(
  parameter int W      = 12,
  parameter int THRESH = 2048
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

  assign hit = (count >= W'(THRESH));

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Grants the gmii_tx frame engine to the video or audio FIFO, steers its reads and enforces the IFG.
// Optional frame statistics are built only when GMII_ARB_STATS_EN is defined.
module gmii_tx_arbiter #(
  parameter int CNT_W       = 11,
  parameter int VID_BURST   = gmii_arb_pkg::VID_BURST,
  parameter int AUD_BURST   = gmii_arb_pkg::AUD_BURST,
  parameter int AUD_TIMEOUT = 2048,
  parameter int IFG_CYCLES  = gmii_arb_pkg::IFG_CYCLES
) (
  input  logic             tx_clk,
  input  logic             sys_rst,
  input  logic [CNT_W-1:0] vid_count,
  input  logic             vid_empty,
  input  logic [CNT_W-1:0] aud_count,
  input  logic             aud_empty,
  output logic             vid_rd_en,
  output logic             aud_rd_en,
  output logic             eng_start,
  output logic             eng_sel,
  output logic [CNT_W-1:0] eng_len,
  input  logic             eng_rd_en,
  input  logic             eng_done,
  output logic             busy,
  output logic             err_underrun,
  output logic             err_len,
  output logic [31:0]      stat_vid_frames,
  output logic [31:0]      stat_aud_frames
);

  import gmii_arb_pkg::*;

  localparam logic [CNT_W-1:0] VID_LEN = CNT_W'(VID_BURST);
  localparam logic [CNT_W-1:0] AUD_LEN = CNT_W'(AUD_BURST);
  localparam int AT_W  = $clog2(AUD_TIMEOUT + 1);
  localparam int IFG_W = $clog2(IFG_CYCLES + 1);

  arb_state_t       state, state_nxt;
  logic             sel_q, last_sel;
  logic [CNT_W-1:0] len_q, wcnt;
  logic             aud_partial, atimeout, ifg_hit;
  logic             vreq, areq, grant, grant_aud;
  logic             sel_empty, rd_req, rd_pass;

  assign aud_partial = (aud_count != '0) && (aud_count < AUD_LEN);
  assign vreq        = (vid_count >= VID_LEN);
  // A stale timeout must not grant an empty audio frame.
  assign areq        = (aud_count >= AUD_LEN) || (atimeout && (aud_count != '0));
  assign grant_aud   = areq && (!vreq || (last_sel == SEL_VID));
  assign grant       = (state == IDLE) && (vreq || areq);

  assign sel_empty = (sel_q == SEL_AUD) ? aud_empty : vid_empty;
  assign rd_req    = (state == BUSY) && eng_rd_en;
  assign rd_pass   = rd_req && !sel_empty && (wcnt < len_q);

  gmii_arb_timer #(.W(AT_W), .THRESH(AUD_TIMEOUT)) u_aud_timer (
    .clk (tx_clk),
    .rst (sys_rst),
    .clr ((grant && grant_aud) || (aud_count == '0)),
    .en  (aud_partial),
    .hit (atimeout)
  );

  // Leaves IFG on the last of IFG_CYCLES cycles spent there.
  gmii_arb_timer #(.W(IFG_W), .THRESH(IFG_CYCLES - 1)) u_ifg_timer (
    .clk (tx_clk),
    .rst (sys_rst),
    .clr (state != IFG),
    .en  (state == IFG),
    .hit (ifg_hit)
  );

  always_ff @(posedge tx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    eng_start = 1'b0;
    busy      = (state != IDLE);
    vid_rd_en = rd_pass && (sel_q == SEL_VID);
    aud_rd_en = rd_pass && (sel_q == SEL_AUD);
    case (state)
      IDLE:    if (vreq || areq) state_nxt = START;
      START: begin
        eng_start = 1'b1;
        state_nxt = BUSY;
      end
      BUSY:    if (eng_done) state_nxt = IFG;
      IFG:     if (ifg_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sel_q        <= SEL_VID;
      last_sel     <= SEL_AUD;
      len_q        <= '0;
      wcnt         <= '0;
      err_underrun <= 1'b0;
      err_len      <= 1'b0;
    end else begin
      if (grant) begin
        sel_q <= grant_aud;
        len_q <= grant_aud ? ((aud_count >= AUD_LEN) ? AUD_LEN : aud_count) : VID_LEN;
      end
      if (state == START) begin
        wcnt <= '0;
      end else if (rd_pass) begin
        wcnt <= wcnt + CNT_W'(1);
      end
      if (rd_req && sel_empty) begin
        err_underrun <= 1'b1;
      end
      if (rd_req && !sel_empty && (wcnt >= len_q)) begin
        err_len <= 1'b1;
      end
      if ((state == BUSY) && eng_done) begin
        if (wcnt != len_q) err_len <= 1'b1;
        last_sel <= sel_q;
      end
    end
  end

  assign eng_sel = sel_q;
  assign eng_len = len_q;

`ifdef GMII_ARB_STATS_EN
  logic [31:0] vid_frames, aud_frames;

  always_ff @(posedge tx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vid_frames <= '0;
      aud_frames <= '0;
    end else if (state == START) begin
      if (sel_q == SEL_AUD) aud_frames <= aud_frames + 32'd1;
      else                  vid_frames <= vid_frames + 32'd1;
    end
  end

  assign stat_vid_frames = vid_frames;
  assign stat_aud_frames = aud_frames;
`else
  assign stat_vid_frames = '0;
  assign stat_aud_frames = '0;
`endif

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed bench for gmii_tx_arbiter with a simple frame-engine model driven from one initial block.
module tb_gmii_tx_arbiter;

  logic        tx_clk;
  logic        sys_rst;
  logic [10:0] vid_count, aud_count;
  logic        vid_empty, aud_empty;
  logic        vid_rd_en, aud_rd_en;
  logic        eng_start, eng_sel;
  logic [10:0] eng_len;
  logic        eng_rd_en, eng_done;
  logic        busy, err_underrun, err_len;
  logic [31:0] stat_vid_frames, stat_aud_frames;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  int cyc, nv, na;

  gmii_tx_arbiter dut (
    .tx_clk          (tx_clk),
    .sys_rst         (sys_rst),
    .vid_count       (vid_count),
    .vid_empty       (vid_empty),
    .aud_count       (aud_count),
    .aud_empty       (aud_empty),
    .vid_rd_en       (vid_rd_en),
    .aud_rd_en       (aud_rd_en),
    .eng_start       (eng_start),
    .eng_sel         (eng_sel),
    .eng_len         (eng_len),
    .eng_rd_en       (eng_rd_en),
    .eng_done        (eng_done),
    .busy            (busy),
    .err_underrun    (err_underrun),
    .err_len         (err_len),
    .stat_vid_frames (stat_vid_frames),
    .stat_aud_frames (stat_aud_frames)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  // A read strobe must never reach the FIFO that is not selected.
  always @(negedge tx_clk) begin
    #2;
    if ((aud_rd_en && !eng_sel) || (vid_rd_en && eng_sel)) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!eng_start && n < 5000) begin
      @(negedge tx_clk);
      eng_done = 1'b0;
      #1;
      n++;
    end
    chk("start_seen", 32'(eng_start), 1);
  endtask

  // Issues nreads engine reads; reads empty_at and empty_at+1 see an empty video FIFO.
  task automatic run_frame(input int nreads, input int empty_at, output int nvid, output int naud);
    nvid = 0;
    naud = 0;
    for (int i = 0; i < nreads; i++) begin
      @(negedge tx_clk);
      eng_rd_en = 1'b1;
      vid_empty = (empty_at >= 0) && (i == empty_at || i == empty_at + 1);
      #1;
      nvid += int'(vid_rd_en);
      naud += int'(aud_rd_en);
    end
    @(negedge tx_clk);
    eng_rd_en = 1'b0;
    vid_empty = 1'b0;
    eng_done  = 1'b1;
  endtask

  initial begin
    sys_rst   = 1'b1;
    eng_rd_en = 1'b0;
    eng_done  = 1'b0;
    vid_empty = 1'b0;
    aud_empty = 1'b0;
    vid_count = 11'd200;
    aud_count = 11'd0;
    repeat (3) @(negedge tx_clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(eng_start), 0);
    chk("rst_len", 32'(eng_len), 0);
    chk("rst_err_underrun", 32'(err_underrun), 0);
    chk("rst_err_len", 32'(err_len), 0);
    chk("rst_stat_vid", stat_vid_frames, 0);

    // Video only: request seen in IDLE on the first edge after release, start visible right after.
    sys_rst = 1'b0;
    wait_start(cyc);
    chk("v1_latency", cyc, 1);
    chk("v1_sel", 32'(eng_sel), 0);
    chk("v1_len", 32'(eng_len), 160);
    run_frame(160, -1, nv, na);
    chk("v1_vid_reads", nv, 160);
    chk("v1_aud_reads", na, 0);
    @(negedge tx_clk);
    eng_done  = 1'b0;
    eng_rd_en = 1'b1;
    #1;
    chk("ifg_rd_ignored", 32'(vid_rd_en), 0);
    chk("ifg_busy", 32'(busy), 1);
    eng_rd_en = 1'b0;
    // 12 IFG cycles plus one IDLE cycle: start shows on the 14th negedge after done.
    wait_start(cyc);
    chk("ifg_gap", cyc + 1, 14);

    // Underrun: two reads hit an empty video FIFO, so only 158 words pass.
    chk("v2_sel", 32'(eng_sel), 0);
    run_frame(160, 50, nv, na);
    chk("ur_vid_reads", nv, 158);
    chk("ur_err_underrun", 32'(err_underrun), 1);
    chk("ur_err_len_before_done", 32'(err_len), 0);
    wait_start(cyc);
    chk("ur_err_len", 32'(err_len), 1);

    // Asynchronous reset in the middle of a BUSY frame.
    @(negedge tx_clk);
    eng_rd_en = 1'b1;
    #1;
    chk("pre_rst_rd", 32'(vid_rd_en), 1);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rd", 32'(vid_rd_en), 0);
    chk("arst_err_underrun", 32'(err_underrun), 0);
    chk("arst_err_len", 32'(err_len), 0);
    chk("arst_len", 32'(eng_len), 0);
    eng_rd_en = 1'b0;
    vid_count = 11'd500;
    aud_count = 11'd20;
    @(negedge tx_clk);
    @(negedge tx_clk);
    sys_rst = 1'b0;

    // Both requesting: V, A, V, A, V.
    wait_start(cyc);
    chk("rr1_latency", cyc, 1);
    chk("rr1_sel", 32'(eng_sel), 0);
    run_frame(160, -1, nv, na);
    chk("rr1_vid_reads", nv, 160);
    wait_start(cyc);
    chk("rr2_sel", 32'(eng_sel), 1);
    chk("rr2_len", 32'(eng_len), 8);
    run_frame(8, -1, nv, na);
    chk("rr2_aud_reads", na, 8);
    chk("rr2_vid_reads", nv, 0);
    wait_start(cyc);
    chk("rr3_sel", 32'(eng_sel), 0);
    run_frame(160, -1, nv, na);
    wait_start(cyc);
    chk("rr4_sel", 32'(eng_sel), 1);
    chk("rr4_len", 32'(eng_len), 8);
    run_frame(8, -1, nv, na);
    chk("rr4_aud_reads", na, 8);
    wait_start(cyc);
    chk("rr5_sel", 32'(eng_sel), 0);
    run_frame(160, -1, nv, na);
`ifdef GMII_ARB_STATS_EN
    chk("stat_vid", stat_vid_frames, 3);
    chk("stat_aud", stat_aud_frames, 2);
`else
    chk("stat_vid", stat_vid_frames, 0);
    chk("stat_aud", stat_aud_frames, 0);
`endif

    // Partial audio backlog: timer reaches 2048 after 2048 edges, start follows one cycle later.
    vid_count = 11'd0;
    aud_count = 11'd3;
    wait_start(cyc);
    chk("to_delay", cyc, 2049);
    chk("to_sel", 32'(eng_sel), 1);
    chk("to_len", 32'(eng_len), 3);
    run_frame(3, -1, nv, na);
    chk("to_aud_reads", na, 3);
    @(negedge tx_clk);
    eng_done = 1'b0;
    repeat (2) @(negedge tx_clk);
    chk("cross_rd", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
